// File: rtl/recording_time_display.sv
// MM:SS.hh stopwatch for the recording path: a prescaler divides the clock down to
// hundredths, and a six-digit BCD counter feeds the downstream seven-segment converters.
module recording_time_display #(
    parameter int CLK_FREQ = 50000000,
    parameter int TICK_HZ  = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    output logic [23:0] digits,
    output logic        running,
    output logic        overflow,
    output logic        tick
);

    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int PW  = (DIV >= 2) ? $clog2(DIV) : 1;

    generate
        if (DIV < 2 || DIV * TICK_HZ != CLK_FREQ) begin : g_bad_div
            $error("recording_time_display: CLK_FREQ/TICK_HZ must be an integer >= 2");
        end
    endgenerate

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [1:0] FULL = 2'd3;

    localparam logic [23:0] MAX_TIME = 24'h595999;

    logic [1:0]    state;
    logic [PW-1:0] prescaler;
    logic [23:0]   digits_next;
    logic          wrap;

    assign wrap = (prescaler == PW'(DIV - 1));

    // Ripple-carry BCD increment; tens of seconds and tens of minutes roll over at 5.
    always_comb begin
        logic       carry;
        logic [3:0] limit;
        digits_next = digits;
        carry       = 1'b1;
        limit       = 4'd9;
        for (int i = 0; i < 6; i++) begin
            limit = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            if (carry) begin
                if (digits[i*4 +: 4] == limit) begin
                    digits_next[i*4 +: 4] = 4'd0;
                end else begin
                    digits_next[i*4 +: 4] = digits[i*4 +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            prescaler <= '0;
            digits    <= '0;
            tick      <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            prescaler <= '0;
            digits    <= '0;
            tick      <= 1'b0;
        end else begin
            tick <= 1'b0;
            case (state)
                IDLE, HOLD: begin
                    if (start && !stop) state <= RUN;
                end
                RUN: begin
                    // The stop cycle still counts, so a pending increment is never lost.
                    if (wrap) begin
                        prescaler <= '0;
                        digits    <= digits_next;
                        tick      <= 1'b1;
                    end else begin
                        prescaler <= prescaler + PW'(1);
                    end
                    if (wrap && digits_next == MAX_TIME) state <= FULL;
                    else if (stop)                       state <= HOLD;
                end
                default: ;
            endcase
        end
    end

    assign running  = (state == RUN);
    assign overflow = (state == FULL);

endmodule

// File: tb/tb_recording_time_display.sv
// Randomized scoreboard bench: an elapsed-centiseconds reference model queues the
// expected outputs for every clock, and a monitor compares them against the DUT.
module tb_recording_time_display;

    localparam int CLK_FREQ = 1000;
    localparam int TICK_HZ  = 100;
    localparam int DIV      = CLK_FREQ / TICK_HZ;
    localparam int MAX_CS   = 359999;

    logic        clk = 1'b0;
    logic        reset, start, stop, clear;
    logic [23:0] digits;
    logic        running, overflow, tick;

    recording_time_display #(.CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .digits(digits), .running(running), .overflow(overflow), .tick(tick)
    );

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_RUN, M_HOLD, M_FULL} mode_t;
    mode_t       m_mode   = M_IDLE;
    int          m_phase  = 0;
    int          m_centis = 0;
    logic        m_tick   = 1'b0;
    logic [26:0] exp_q[$];
    logic [23:0] ff_digits;
    int          checks = 0;
    int          passed = 0;

    function automatic logic [23:0] to_digits(input int c);
        int mm, ss, hh;
        mm = c / 6000;
        ss = (c / 100) % 60;
        hh = c % 100;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(hh / 10), 4'(hh % 10)};
    endfunction

    // Reference model: time kept as whole centiseconds, digits derived by division.
    initial forever begin
        @(posedge clk);
        if (reset || clear) begin
            m_mode = M_IDLE; m_phase = 0; m_centis = 0; m_tick = 1'b0;
        end else begin
            m_tick = 1'b0;
            case (m_mode)
                M_IDLE, M_HOLD: if (start && !stop) m_mode = M_RUN;
                M_RUN: begin
                    m_phase++;
                    if (m_phase == DIV) begin
                        m_phase = 0;
                        m_centis++;
                        m_tick = 1'b1;
                    end
                    if (m_centis == MAX_CS) m_mode = M_FULL;
                    else if (stop)          m_mode = M_HOLD;
                end
                default: ;
            endcase
        end
        exp_q.push_back({to_digits(m_centis), m_mode == M_RUN, m_mode == M_FULL, m_tick});
    end

    task automatic checkOutput();
        logic [26:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({digits, running, overflow, tick} === e) passed++;
            else $display("[TB] FAIL outputs t=%0t got digits=%h run=%b ovf=%b tick=%b expected digits=%h run=%b ovf=%b tick=%b",
                          $time, digits, running, overflow, tick, e[26:3], e[2], e[1], e[0]);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #3;
        checkOutput();
    end

    task automatic applyStimulus(input logic s, input logic p, input logic c, input logic r, input int n);
        start = s; stop = p; clear = c; reset = r;
        repeat (n) @(negedge clk);
    endtask

    // Jump the counter ahead so the long carries and saturation are reachable quickly.
    task automatic fastForward(input int c);
        ff_digits = to_digits(c);
        m_centis  = c;
        force dut.digits = ff_digits;
        #1;
        release dut.digits;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
        @(negedge clk);
        applyStimulus(0, 0, 0, 1, 2);
        applyStimulus(0, 0, 0, 0, 50);
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1005);
        applyStimulus(0, 0, 1, 0, 1);
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 3);
        applyStimulus(0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 100);
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 20);
        fastForward(5990);
        applyStimulus(0, 0, 0, 0, 150);
        fastForward(MAX_CS - 9);
        applyStimulus(0, 0, 0, 0, 120);
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 5);
        applyStimulus(0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 5);
        applyStimulus(1, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 5);
        applyStimulus(0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 5);
        applyStimulus(1, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 5);
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 15);
        applyStimulus(1, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 5);
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 25);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 5);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) fastForward($urandom_range(MAX_CS - 99, MAX_CS - 1));
            applyStimulus($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 3,
                          $urandom_range(0, 199) < 2, $urandom_range(0, 499) < 1, 1);
        end
        applyStimulus(0, 0, 0, 0, 3);
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("[TB] FAIL queue_drain got %0d pending expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
